// File: rtl/fifo_multicanal.sv
// Bank of independent first-word-fall-through FIFO channels with occupancy count and sticky error flags.
// Optional almost-full/almost-empty outputs are enabled with FIFO_MULTICANAL_ALMOST_EN.
module fifo_multicanal #(
    parameter int width   = 16,
    parameter int depth   = 8,
    parameter int devices = 4,
`ifdef FIFO_MULTICANAL_ALMOST_EN
    parameter int almost_lvl = 2,
`endif
    localparam int CW = $clog2(depth + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [devices*width-1:0]   dato_i,
    input  logic [devices-1:0]         push_i,
    input  logic [devices-1:0]         pop_i,
    input  logic [devices-1:0]         clr_err_i,
    output logic [devices*width-1:0]   dato_o,
    output logic [devices-1:0]         pndng_o,
    output logic [devices-1:0]         full_o,
    output logic [devices-1:0]         empty_o,
    output logic [devices*CW-1:0]      count_o,
    output logic [devices-1:0]         overflow_o,
`ifdef FIFO_MULTICANAL_ALMOST_EN
    output logic [devices-1:0]         almost_full_o,
    output logic [devices-1:0]         almost_empty_o,
`endif
    output logic [devices-1:0]         underflow_o
);

    localparam int PW = $clog2(depth);

    for (genvar k = 0; k < devices; k++) begin : g_ch
        logic [width-1:0] r_mem [depth];
        logic [PW-1:0]    r_rp;
        logic [PW-1:0]    r_wp;
        logic [CW-1:0]    r_cnt;
        logic             r_ovf;
        logic             r_unf;
        logic             w_empty;
        logic             w_full;
        logic             w_pop_ok;
        logic             w_push_ok;
        logic [PW-1:0]    w_rp_nxt;
        logic [PW-1:0]    w_wp_nxt;

        assign w_empty   = (r_cnt == '0);
        assign w_full    = (r_cnt == CW'(depth));
        assign w_pop_ok  = pop_i[k] && !w_empty;
        // A full channel still takes a push when the head leaves in the same cycle.
        assign w_push_ok = push_i[k] && (!w_full || w_pop_ok);
        assign w_rp_nxt  = (r_rp == PW'(depth - 1)) ? '0 : r_rp + PW'(1);
        assign w_wp_nxt  = (r_wp == PW'(depth - 1)) ? '0 : r_wp + PW'(1);

        always_ff @(posedge clk) begin
            if (rst && w_push_ok) begin
                r_mem[r_wp] <= dato_i[k*width +: width];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                r_rp  <= '0;
                r_wp  <= '0;
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_push_ok) r_wp <= w_wp_nxt;
                if (w_pop_ok)  r_rp <= w_rp_nxt;
                if (w_push_ok && !w_pop_ok)      r_cnt <= r_cnt + CW'(1);
                else if (w_pop_ok && !w_push_ok) r_cnt <= r_cnt - CW'(1);
                // New errors take priority over a clear in the same cycle.
                if (push_i[k] && !w_push_ok) r_ovf <= 1'b1;
                else if (clr_err_i[k])       r_ovf <= 1'b0;
                if (pop_i[k] && !w_pop_ok)   r_unf <= 1'b1;
                else if (clr_err_i[k])       r_unf <= 1'b0;
            end
        end

        assign dato_o[k*width +: width] = w_empty ? '0 : r_mem[r_rp];
        assign count_o[k*CW +: CW]      = r_cnt;
        assign pndng_o[k]               = !w_empty;
        assign empty_o[k]               = w_empty;
        assign full_o[k]                = w_full;
        assign overflow_o[k]            = r_ovf;
        assign underflow_o[k]           = r_unf;
`ifdef FIFO_MULTICANAL_ALMOST_EN
        assign almost_full_o[k]         = (r_cnt >= CW'(depth - almost_lvl));
        assign almost_empty_o[k]        = (r_cnt <= CW'(almost_lvl));
`endif
    end

endmodule

// File: tb/tb_fifo_multicanal.sv
// Scoreboard bench for fifo_multicanal: a depth-8 four-channel bank and a depth-5 single channel.
module tb_fifo_multicanal;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int CW  = 4;
    localparam int CW5 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [N*W-1:0]  dato_i, dato_o;
    logic [N-1:0]    push_i, pop_i, clr_i, pndng, full, empty, ovf, unf;
    logic [N*CW-1:0] count;

    logic [W-1:0]    dato_i5, dato_o5;
    logic            push5, pop5, clr5, pndng5, full5, empty5, ovf5, unf5;
    logic [CW5-1:0]  count5;

`ifdef FIFO_MULTICANAL_ALMOST_EN
    logic [N-1:0] af, ae;
    logic         af5, ae5;
`endif

    fifo_multicanal #(.width(W), .depth(8), .devices(N)) dut8 (
        .clk(clk), .rst(rst), .dato_i(dato_i), .push_i(push_i), .pop_i(pop_i),
        .clr_err_i(clr_i), .dato_o(dato_o), .pndng_o(pndng), .full_o(full),
        .empty_o(empty), .count_o(count), .overflow_o(ovf),
`ifdef FIFO_MULTICANAL_ALMOST_EN
        .almost_full_o(af), .almost_empty_o(ae),
`endif
        .underflow_o(unf));

    fifo_multicanal #(.width(W), .depth(5), .devices(1)) dut5 (
        .clk(clk), .rst(rst), .dato_i(dato_i5), .push_i(push5), .pop_i(pop5),
        .clr_err_i(clr5), .dato_o(dato_o5), .pndng_o(pndng5), .full_o(full5),
        .empty_o(empty5), .count_o(count5), .overflow_o(ovf5),
`ifdef FIFO_MULTICANAL_ALMOST_EN
        .almost_full_o(af5), .almost_empty_o(ae5),
`endif
        .underflow_o(unf5));

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q [N][$];
    logic [W-1:0] q5 [$];
    logic [W-1:0] m_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] dat(input int ch);
        return dato_o[ch*W +: W];
    endfunction

    function automatic logic [CW-1:0] cnt(input int ch);
        return count[ch*CW +: CW];
    endfunction

    // Popped data checked at the negedge before the edge that consumes it.
    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < N; k++) begin
                if (pop_i[k] && pndng[k]) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL pop_ch%0d: got 0x%0h expected no entry", k, dato_o[k*W +: W]);
                    end else begin
                        m_exp = q[k].pop_front();
                        if (dato_o[k*W +: W] !== m_exp) begin
                            errors++;
                            $display("FAIL pop_ch%0d: got 0x%0h expected 0x%0h", k, dato_o[k*W +: W], m_exp);
                        end
                    end
                end
            end
            if (pop5 && pndng5) begin
                checks++;
                if (q5.size() == 0) begin
                    errors++;
                    $display("FAIL pop_d5: got 0x%0h expected no entry", dato_o5);
                end else begin
                    m_exp = q5.pop_front();
                    if (dato_o5 !== m_exp) begin
                        errors++;
                        $display("FAIL pop_d5: got 0x%0h expected 0x%0h", dato_o5, m_exp);
                    end
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] pu, input logic [N-1:0] po,
                        input logic [N-1:0] cl, input logic [N*W-1:0] d);
        push_i = pu; pop_i = po; clr_i = cl; dato_i = d;
        @(posedge clk); #1;
        push_i = '0; pop_i = '0; clr_i = '0;
    endtask

    task automatic push1(input int ch, input logic [W-1:0] v, input bit acc);
        logic [N*W-1:0] d;
        d = '0;
        d[ch*W +: W] = v;
        if (acc) q[ch].push_back(v);
        step(N'(1) << ch, '0, '0, d);
    endtask

    task automatic pop1(input int ch);
        step('0, N'(1) << ch, '0, '0);
    endtask

    task automatic step5(input logic pu, input logic po, input logic [W-1:0] v);
        push5 = pu; pop5 = po; dato_i5 = v;
        if (pu) q5.push_back(v);
        @(posedge clk); #1;
        push5 = 1'b0; pop5 = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] d;
        rst = 1'b0;
        push_i = '0; pop_i = '0; clr_i = '0; dato_i = '0;
        push5 = 1'b0; pop5 = 1'b0; clr5 = 1'b0; dato_i5 = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_count%0d", k), cnt(k), 0);
            chk($sformatf("rst_empty%0d", k), empty[k], 1);
            chk($sformatf("rst_pndng%0d", k), pndng[k], 0);
            chk($sformatf("rst_full%0d", k), full[k], 0);
            chk($sformatf("rst_flags%0d", k), {ovf[k], unf[k]}, 0);
            chk($sformatf("rst_dato%0d", k), dat(k), 0);
        end
        chk("rst_empty_d5", empty5, 1);
        rst = 1'b1;

        // Basic push/pop on channel 0
        push1(0, 16'h0006, 1);
        push1(0, 16'h000A, 1);
        chk("t1_count", cnt(0), 2);
        chk("t1_head", dat(0), 16'h0006);
        pop1(0);
        chk("t1_head2", dat(0), 16'h000A);
        pop1(0);
        chk("t1_empty", empty[0], 1);
        chk("t1_dato0", dat(0), 0);

        // Fill, overflow, drain, clear on channel 2
        for (int i = 0; i < 8; i++) push1(2, 16'h0100 + 16'(i), 1);
        chk("t2_full", full[2], 1);
        push1(2, 16'hFFFF, 0);
        chk("t2_ovf", ovf[2], 1);
        chk("t2_count", cnt(2), 8);
        chk("t2_head", dat(2), 16'h0100);
        for (int i = 0; i < 8; i++) pop1(2);
        chk("t2_empty", empty[2], 1);
        step('0, '0, 4'b0100, '0);
        chk("t2_ovf_clr", ovf[2], 0);

        // Push+pop while full and while empty on channel 1
        for (int i = 0; i < 8; i++) push1(1, 16'h1100 + 16'(i), 1);
        d = '0; d[W +: W] = 16'h11AA; q[1].push_back(16'h11AA);
        step(4'b0010, 4'b0010, '0, d);
        chk("t3_full_count", cnt(1), 8);
        chk("t3_full_ovf", ovf[1], 0);
        chk("t3_full_head", dat(1), 16'h1101);
        for (int i = 0; i < 8; i++) pop1(1);
        chk("t3_drained", empty[1], 1);
        d = '0; d[W +: W] = 16'h1B0B; q[1].push_back(16'h1B0B);
        step(4'b0010, 4'b0010, '0, d);
        chk("t3_empty_count", cnt(1), 1);
        chk("t3_empty_unf", unf[1], 1);
        chk("t3_empty_head", dat(1), 16'h1B0B);
        pop1(1);
        step('0, 4'b0010, 4'b0010, '0);
        chk("t3_set_wins", unf[1], 1);
        step('0, '0, 4'b0010, '0);
        chk("t3_unf_clr", unf[1], 0);

        // Channel independence
        d = '0; d[0 +: W] = 16'hA0A0; d[3*W +: W] = 16'h3C3C;
        q[0].push_back(16'hA0A0); q[3].push_back(16'h3C3C);
        step(4'b1001, '0, '0, d);
        pop1(3);
        chk("t4_count0", cnt(0), 1);
        chk("t4_head0", dat(0), 16'hA0A0);
        chk("t4_empty_mask", empty, 4'b1110);
        chk("t4_flags0", {ovf[0], unf[0]}, 0);

        // Reset with entries stored
        for (int i = 1; i < 4; i++) push1(0, 16'hA0A0 + 16'(i), 1);
        chk("t5_count_pre", cnt(0), 4);
        pop1(2);
        chk("t5_unf_pre", unf[2], 1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        q[0].delete();
        chk("t5_count", cnt(0), 0);
        chk("t5_empty", empty[0], 1);
        chk("t5_unf", unf[2], 0);
        chk("t5_dato", dat(0), 0);
        push1(0, 16'h1234, 1);
        chk("t5_head", dat(0), 16'h1234);
        pop1(0);

        // Wrap-around on the depth-5 instance
        for (int i = 0; i < 5; i++) step5(1'b1, 1'b0, 16'h0050 + 16'(i));
        chk("t6_full_a", full5, 1);
        for (int i = 0; i < 3; i++) step5(1'b0, 1'b1, '0);
        chk("t6_count_mid", count5, 2);
        for (int i = 5; i < 8; i++) step5(1'b1, 1'b0, 16'h0050 + 16'(i));
        chk("t6_count", count5, 5);
        chk("t6_full_b", full5, 1);
        for (int i = 0; i < 5; i++) step5(1'b0, 1'b1, '0);
        chk("t6_empty", empty5, 1);
        chk("t6_dato", dato_o5, 0);

        for (int k = 0; k < N; k++) chk($sformatf("sb_left%0d", k), q[k].size(), 0);
        chk("sb_left_d5", q5.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
